// File: rtl/openhw_fdivsqrtctrl_pkg.sv
// Shared types for the divide/square-root control slice: configuration
// record and the controller state encoding.
package openhw_fdivsqrtctrl_pkg;

  typedef struct packed {
    int unsigned DURLEN;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{DURLEN: 6};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divsqrtstate_t;

endpackage

// File: rtl/openhw_fdivsqrtstepcnt.sv
// Loadable iteration down-counter for the div/sqrt controller.
// A load of zero is promoted to one so every iterating operation runs at least one step.
module openhw_fdivsqrtstepcnt
  import openhw_fdivsqrtctrl_pkg::*;
#(
  parameter cvw_t P = CVW_RV64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                dec,
  input  logic                clr,
  input  logic [P.DURLEN-1:0] load_val,
  output logic                eq1
);

  localparam int unsigned W = P.DURLEN;

  logic [W-1:0] count_reg, count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_reg <= '0;
    else       count_reg <= count_next;
  end

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (load)
      count_next = (load_val == '0) ? W'(1) : load_val;
    else if (dec)
      count_next = count_reg - W'(1);
  end

  assign eq1 = (count_reg == W'(1));

endmodule

// File: rtl/openhw_fdivsqrtctrl.sv
// Div/sqrt control FSM: issues the datapath load pulse and iteration enable,
// counts iterations, bypasses special cases and holds DONE across Memory stalls.
module openhw_fdivsqrtctrl
  import openhw_fdivsqrtctrl_pkg::*;
#(
  parameter cvw_t P = CVW_RV64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FDivStartE,
  input  logic                IDivStartE,
  input  logic                SpecialCaseE,
  input  logic [P.DURLEN-1:0] CyclesE,
  input  logic                StallM,
  input  logic                FlushE,
  output logic                IFDivStartE,
  output logic                IterEnE,
  output logic                FDivBusyE,
  output logic                FDivDoneE,
  output logic                SpecialCaseM
);

  divsqrtstate_t state_reg, state_next;
  logic          start;
  logic          cnt_eq1;
  logic          cnt_load, cnt_dec, cnt_clr;

  // Reset gates start so every output is low while reset is held.
  assign start = (FDivStartE | IDivStartE) & ~FlushE & (state_reg == IDLE) & ~reset;

  assign cnt_load = start & ~SpecialCaseE;
  assign cnt_clr  = (state_reg == BUSY) & FlushE;
  assign cnt_dec  = (state_reg == BUSY) & ~FlushE & ~cnt_eq1;

  openhw_fdivsqrtstepcnt #(.P(P)) u_stepcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .load_val (CyclesE),
    .eq1      (cnt_eq1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      SpecialCaseM <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) SpecialCaseM <= SpecialCaseE;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = SpecialCaseE ? DONE : BUSY;
      end
      BUSY: begin
        if (FlushE)       state_next = IDLE;
        else if (cnt_eq1) state_next = DONE;
      end
      DONE: begin
        if (FlushE || !StallM) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IFDivStartE = start;
    IterEnE     = start | (state_reg == BUSY);
    FDivBusyE   = (state_reg == BUSY) | start | ((state_reg == DONE) & StallM);
    FDivDoneE   = (state_reg == DONE);
  end

endmodule

// File: tb/tb_openhw_fdivsqrtctrl.sv
// Scoreboard bench for the div/sqrt controller: the driver queues the expected
// output vector for each cycle, the monitor checks it on the falling edge.
module tb_openhw_fdivsqrtctrl;
  import openhw_fdivsqrtctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       FDivStartE, IDivStartE, SpecialCaseE, StallM, FlushE;
  logic [5:0] CyclesE;
  logic       IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SpecialCaseM;

  typedef struct {
    logic [4:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic sc_m   = 1'b0;

  openhw_fdivsqrtctrl dut (
    .clk          (clk),
    .reset        (reset),
    .FDivStartE   (FDivStartE),
    .IDivStartE   (IDivStartE),
    .SpecialCaseE (SpecialCaseE),
    .CyclesE      (CyclesE),
    .StallM       (StallM),
    .FlushE       (FlushE),
    .IFDivStartE  (IFDivStartE),
    .IterEnE      (IterEnE),
    .FDivBusyE    (FDivBusyE),
    .FDivDoneE    (FDivDoneE),
    .SpecialCaseM (SpecialCaseM)
  );

  always #5 clk = ~clk;

  // Vector order: {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SpecialCaseM}
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [4:0] got;
      e   = sb.pop_front();
      got = {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SpecialCaseM};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b (ifs,iter,busy,done,scm)", e.tag, got, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ev(bit ifs, bit it, bit bz, bit dn);
    return {ifs, it, bz, dn, sc_m};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [4:0] v, string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    FDivStartE   = 1'b0;
    IDivStartE   = 1'b0;
    SpecialCaseE = 1'b0;
    StallM       = 1'b0;
    FlushE       = 1'b0;
    CyclesE      = 6'd0;
  endtask

  // One operation: flush_at = -1 none, 0 flush with start, k flush at BUSY cycle k.
  task automatic run_op(string name, bit fd, bit id, bit sc, int cyc, int stall,
                        int flush_at, bit hold);
    int n;
    n = (cyc == 0) ? 1 : cyc;
    next();
    FDivStartE   = fd;
    IDivStartE   = id;
    SpecialCaseE = sc;
    CyclesE      = 6'(cyc);
    StallM       = 1'b0;
    FlushE       = (flush_at == 0);
    if (flush_at == 0) begin
      push(ev(0, 0, 0, 0), {name, "_t0"});
      next();
      idle_inputs();
      push(ev(0, 0, 0, 0), {name, "_t1"});
      $display("TXN %s start+flush cycles=%0d", name, cyc);
      return;
    end
    push(ev(1, 1, 1, 0), {name, "_start"});
    sc_m = sc;
    if (!sc) begin
      for (int k = 1; k <= n; k++) begin
        next();
        FDivStartE   = hold & fd;
        IDivStartE   = hold & id;
        SpecialCaseE = ~sc;
        CyclesE      = 6'd1;
        FlushE       = (k == flush_at);
        push(ev(0, 1, 1, 0), $sformatf("%s_busy%0d", name, k));
        if (k == flush_at) begin
          $display("TXN %s flushed at busy cycle %0d of %0d", name, k, n);
          return;
        end
      end
    end
    for (int s = 0; s <= stall; s++) begin
      next();
      FDivStartE = 1'b0;
      IDivStartE = 1'b0;
      FlushE     = 1'b0;
      StallM     = (s < stall);
      push(ev(0, 0, s < stall, 1), $sformatf("%s_done%0d", name, s));
    end
    next();
    idle_inputs();
    push(ev(0, 0, 0, 0), {name, "_idle"});
    $display("TXN %s cycles=%0d special=%0d stall=%0d latency=%0d",
             name, cyc, sc, stall, sc ? 1 : n + 1);
  endtask

  task automatic reset_mid_op();
    next();
    FDivStartE   = 1'b1;
    SpecialCaseE = 1'b0;
    CyclesE      = 6'd5;
    push(ev(1, 1, 1, 0), "rst_start");
    sc_m = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      next();
      FDivStartE = 1'b0;
      push(ev(0, 1, 1, 0), $sformatf("rst_busy%0d", k));
    end
    next();
    #2 reset = 1'b1;
    sc_m = 1'b0;
    push(ev(0, 0, 0, 0), "rst_async_t3");
    next();
    push(ev(0, 0, 0, 0), "rst_held");
    next();
    reset = 1'b0;
    push(ev(0, 0, 0, 0), "rst_release");
    $display("TXN async reset at t3 of 5-cycle op");
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      next();
      push(ev(0, 0, 0, 0), "reset");
    end
    next();
    reset = 1'b0;
    push(ev(0, 0, 0, 0), "post_reset");

    run_op("basic5",      1, 0, 0, 5,  0, -1, 0);
    run_op("special",     0, 1, 1, 9,  0, -1, 0);
    run_op("stall3",      1, 0, 0, 3,  2, -1, 0);
    run_op("flush10",     1, 0, 0, 10, 0,  4, 0);
    run_op("restart10",   1, 0, 0, 10, 0, -1, 0);
    run_op("cyc0",        1, 0, 0, 0,  0, -1, 0);
    run_op("cyc1",        0, 1, 0, 1,  0, -1, 0);
    run_op("cyc63_hold",  1, 0, 0, 63, 0, -1, 1);
    run_op("sp_stall",    1, 0, 1, 4,  1, -1, 0);
    run_op("startflush",  1, 1, 0, 5,  0,  0, 0);
    reset_mid_op();
    run_op("fresh2",      0, 1, 0, 2,  0, -1, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
